// File: rtl/uart_word_tx_bridge_pkg.sv
// uart_pkg: shared byte width and Tx FSM state encoding for the word-to-byte bridge.
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;
endpackage

// File: rtl/uart_word_tx_bridge_if.sv
// uart_word_tx_bridge_if: host word port, host read port and UART top register port.
interface uart_word_tx_bridge_if import uart_pkg::*; #(parameter int WORD_BYTES = 4);
  logic                              s_valid;
  logic                              s_ready;
  logic [UART_BYTE_W*WORD_BYTES-1:0] s_data;
  logic                              write_reg_en;
  logic [UART_BYTE_W-1:0]            write_reg_in;
  logic                              rd_req;
  logic                              read_reg_en;
  logic [UART_BYTE_W-1:0]            read_reg_out;
  logic                              rd_valid;
  logic [UART_BYTE_W-1:0]            rd_data;
  logic                              busy;
  modport master (
    output s_valid, s_data, rd_req, read_reg_out,
    input  s_ready, write_reg_en, write_reg_in, read_reg_en, rd_valid, rd_data, busy
  );
  modport slave (
    input  s_valid, s_data, rd_req, read_reg_out,
    output s_ready, write_reg_en, write_reg_in, read_reg_en, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/uart_word_tx_bridge_gap_timer.sv
// uart_gap_timer: inter-byte gap counter; done while the count sits at 1.
module uart_gap_timer #(
  parameter int BYTE_GAP = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);
  localparam int W = $clog2(BYTE_GAP + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else if (i_load) r_cnt <= W'(BYTE_GAP);
    else if (i_count && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end
  assign o_done = r_cnt == W'(1);
endmodule

// File: rtl/uart_word_tx_bridge.sv
// uart_word_tx_bridge: serialises host words into paced UART byte writes and services byte reads.
module uart_word_tx_bridge import uart_pkg::*; #(
  parameter int WORD_BYTES = 4,
  parameter int BYTE_GAP   = 16,
  parameter bit LSB_FIRST  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  uart_word_tx_bridge_if.slave bus
);
  localparam int WORD_W = UART_BYTE_W * WORD_BYTES;
  localparam int CNT_W  = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
  tx_state_t              r_state;
  logic [CNT_W-1:0]       r_byte_cnt;
  logic [WORD_W-1:0]      r_buf;
  logic                   r_wen;
  logic [UART_BYTE_W-1:0] r_wdata;
  logic [2:0]             r_rd;
  logic [UART_BYTE_W-1:0] r_rd_data;
  logic                   w_done;
  logic                   w_last;
  function automatic logic [UART_BYTE_W-1:0] sel_byte(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] i);
    int idx;
    idx = LSB_FIRST ? int'(i) : WORD_BYTES - 1 - int'(i);
    return w[UART_BYTE_W*idx +: UART_BYTE_W];
  endfunction
  uart_gap_timer #(.BYTE_GAP(BYTE_GAP)) u_gap (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == TX_SEND),
    .i_count(r_state == TX_GAP),
    .o_done (w_done)
  );
  assign w_last = r_byte_cnt == CNT_W'(WORD_BYTES - 1);
  // The strobe is registered alongside the move into SEND so it lines up with that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= TX_IDLE;
      r_byte_cnt <= '0;
      r_buf      <= '0;
      r_wen      <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        TX_IDLE: if (bus.s_valid) begin
          r_buf      <= bus.s_data;
          r_byte_cnt <= '0;
          r_state    <= TX_SEND;
          r_wen      <= 1'b1;
          r_wdata    <= sel_byte(bus.s_data, '0);
        end
        TX_SEND: r_state <= TX_GAP;
        TX_GAP: if (w_done) begin
          if (w_last) r_state <= TX_IDLE;
          else begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_state    <= TX_SEND;
            r_wen      <= 1'b1;
            r_wdata    <= sel_byte(r_buf, r_byte_cnt + 1'b1);
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end
  // One-hot read pipeline: strobe, wait for the register to update, capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd      <= '0;
      r_rd_data <= '0;
    end else begin
      r_rd <= {r_rd[1:0], bus.rd_req && r_rd[1:0] == 2'b00};
      if (r_rd[1]) r_rd_data <= bus.read_reg_out;
    end
  end
  assign bus.s_ready      = r_state == TX_IDLE;
  assign bus.busy         = r_state != TX_IDLE;
  assign bus.write_reg_en = r_wen;
  assign bus.write_reg_in = r_wdata;
  assign bus.read_reg_en  = r_rd[0];
  assign bus.rd_valid     = r_rd[2];
  assign bus.rd_data      = r_rd_data;
endmodule
